// File: rtl/rgb_to_colour.sv
// -----------------------------------------------------------------------------
// rgb_to_colour
// Reverse palette lookup: maps a 24-bit RGB key back to the 3-bit colour index
// whose palette entry matches it. The 8-entry palette lives in registers but is
// scanned one entry per clock, as a single-read-port memory would be.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous active-high reset
//   enable   in   1   FSM clock-enable; low freezes scan state and outputs
//   start    in   1   lookup request, taken when start & ready & enable
//   rgb      in  24   lookup key, sampled on acceptance
//   wr_en    in   1   palette write strobe (independent of enable)
//   wr_addr  in   3   palette entry to write
//   wr_data  in  24   palette write data
//   ready    out  1   high while idle
//   valid    out  1   result strobe
//   hit      out  1   1 = match found, held until the next result
//   colour   out  3   matching index (0 on a miss), held until the next result
// -----------------------------------------------------------------------------
module rgb_to_colour #(
    parameter logic [23:0] MATCH_MASK = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    input  logic [23:0] rgb,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [23:0] wr_data,
    output logic        ready,
    output logic        valid,
    output logic        hit,
    output logic [2:0]  colour
);

    localparam int unsigned RGB_W     = 24;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned N_ENTRIES = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [RGB_W-1:0]   key_q, key_d;
    logic               valid_q, valid_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   colour_q, colour_d;
    logic               ready_q, ready_d;

    logic [RGB_W-1:0]   palette_q [N_ENTRIES];
    logic               entry_match_c;

    // Default palette: index bits select full-scale R, G and B channels.
    function automatic logic [RGB_W-1:0] default_entry(input logic [IDX_W-1:0] idx);
        return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    endfunction

    // Palette storage; writes proceed regardless of enable or FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                palette_q[i] <= default_entry(IDX_W'(i));
            end
        end else if (wr_en) begin
            palette_q[wr_addr] <= wr_data;
        end
    end

    // Reads the pre-edge palette value, so a same-edge write to the compared
    // entry is not seen until the following scan.
    assign entry_match_c = ((palette_q[ptr_q] & MATCH_MASK) == (key_q & MATCH_MASK));

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        key_d    = key_q;
        valid_d  = valid_q;
        hit_d    = hit_q;
        colour_d = colour_q;

        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        key_d   = rgb;
                        ptr_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    // Scan runs upward from 0, so the first hit is the lowest index.
                    if (entry_match_c) begin
                        colour_d = ptr_q;
                        hit_d    = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (ptr_q == LAST_IDX) begin
                        colour_d = '0;
                        hit_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ready_d = (state_d == IDLE);
    end

    // FSM and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            colour_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
            colour_q <= colour_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign valid  = valid_q;
    assign hit    = hit_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_rgb_to_colour.sv
// -----------------------------------------------------------------------------
// tb_rgb_to_colour
// Directed bench for rgb_to_colour: a default-mask instance for the main
// lookups and an F0F0F0-mask instance for masked matching and same-edge writes.
// -----------------------------------------------------------------------------
module tb_rgb_to_colour;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;

    logic        start;
    logic [23:0] rgb;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        ready, valid, hit;
    logic [2:0]  colour;

    logic        start_m;
    logic [23:0] rgb_m;
    logic        wr_en_m;
    logic [2:0]  wr_addr_m;
    logic [23:0] wr_data_m;
    logic        ready_m, valid_m, hit_m;
    logic [2:0]  colour_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rgb_to_colour u_dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .start   (start),
        .rgb     (rgb),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready),
        .valid   (valid),
        .hit     (hit),
        .colour  (colour)
    );

    rgb_to_colour #(.MATCH_MASK(24'hF0F0F0)) u_dut_m (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .start   (start_m),
        .rgb     (rgb_m),
        .wr_en   (wr_en_m),
        .wr_addr (wr_addr_m),
        .wr_data (wr_data_m),
        .ready   (ready_m),
        .valid   (valid_m),
        .hit     (hit_m),
        .colour  (colour_m)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick until the selected instance raises valid; edge_no counts edges since acceptance.
    task automatic wait_valid(input bit sel_m, input int from_edge, output int edge_no);
        edge_no = from_edge;
        while (!(sel_m ? valid_m : valid) && edge_no < 40) begin
            tick();
            edge_no++;
        end
    endtask

    // Full lookup on the default-mask instance with result and timing checks.
    task automatic lookup(input string tag, input logic [23:0] key,
                          input logic exp_hit, input logic [2:0] exp_col, input int exp_edge);
        int e;
        chk({tag, "_ready_pre"}, 32'(ready), 32'(1));
        start = 1'b1;
        rgb   = key;
        tick();                         // E0
        start = 1'b0;
        rgb   = ~key;                   // key must already be latched
        chk({tag, "_ready_busy"}, 32'(ready), 32'(0));
        wait_valid(1'b0, 0, e);
        chk({tag, "_edge"}, 32'(e), 32'(exp_edge));
        chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        chk({tag, "_colour"}, 32'(colour), 32'(exp_col));
        tick();
        chk({tag, "_valid_drop"}, 32'(valid), 32'(0));
        chk({tag, "_ready_back"}, 32'(ready), 32'(1));
        chk({tag, "_colour_held"}, 32'(colour), 32'(exp_col));
    endtask

    task automatic write_entry(input logic [2:0] addr, input logic [23:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int e;
        bit saw_valid;

        rst = 1'b1; enable = 1'b1;
        start = 1'b0; rgb = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start_m = 1'b0; rgb_m = '0; wr_en_m = 1'b0; wr_addr_m = '0; wr_data_m = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_hit", 32'(hit), 32'(0));
        chk("rst_colour", 32'(colour), 32'(0));

        // Default-palette hit and miss
        lookup("green", 24'h00FF00, 1'b1, 3'd2, 3);
        lookup("miss", 24'h123456, 1'b0, 3'd0, 8);

        // Written entries, lowest index wins
        write_entry(3'd5, 24'h123456);
        lookup("wr5", 24'h123456, 1'b1, 3'd5, 6);
        write_entry(3'd2, 24'hFF0000);
        lookup("lowest", 24'hFF0000, 1'b1, 3'd2, 3);

        // enable low for 3 edges mid-scan, plus an ignored start
        start = 1'b1; rgb = 24'hFFFFFF;
        tick();                         // E0
        start = 1'b0;
        tick();                         // E1
        tick();                         // E2
        enable = 1'b0;
        start  = 1'b1; rgb = 24'h0000FF;
        tick();                         // E3 frozen
        start  = 1'b0;
        tick();                         // E4 frozen
        tick();                         // E5 frozen
        chk("frz_valid", 32'(valid), 32'(0));
        chk("frz_ready", 32'(ready), 32'(0));
        enable = 1'b1;
        wait_valid(1'b0, 5, e);
        chk("frz_edge", 32'(e), 32'(11));
        chk("frz_hit", 32'(hit), 32'(1));
        chk("frz_colour", 32'(colour), 32'(7));
        // valid stretches while enable is low
        enable = 1'b0;
        tick();
        tick();
        chk("stretch_valid", 32'(valid), 32'(1));
        enable = 1'b1;
        tick();
        chk("stretch_drop", 32'(valid), 32'(0));
        chk("stretch_ready", 32'(ready), 32'(1));
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid || !ready) saw_valid = 1'b1;
        end
        chk("start_not_queued", 32'(saw_valid), 32'(0));

        // Reset mid-scan, overriding a same-cycle write
        start = 1'b1; rgb = 24'hFFFFFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h00FF00;
        tick();
        rst = 1'b0;
        wr_en = 1'b0;
        chk("abort_valid", 32'(valid), 32'(0));
        chk("abort_ready", 32'(ready), 32'(1));
        chk("abort_colour", 32'(colour), 32'(0));
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) saw_valid = 1'b1;
        end
        chk("abort_no_pulse", 32'(saw_valid), 32'(0));
        lookup("dflt_blue", 24'h0000FF, 1'b1, 3'd1, 2);
        lookup("dflt_green", 24'h00FF00, 1'b1, 3'd2, 3);
        lookup("dflt_miss", 24'h123456, 1'b0, 3'd0, 8);

        // Masked instance: 0A0BFF & F0F0F0 = 0000F0 matches entry 1 (0000FF)
        chk("m_ready", 32'(ready_m), 32'(1));
        start_m = 1'b1; rgb_m = 24'h0A0BFF;
        tick();                         // E0
        start_m = 1'b0;
        tick();                         // E1: entry 0 compared
        chk("m_e1_valid", 32'(valid_m), 32'(0));
        wr_en_m = 1'b1; wr_addr_m = 3'd1; wr_data_m = 24'h000000;
        tick();                         // E2: entry 1 compared with old value, written
        wr_en_m = 1'b0;
        chk("m_valid", 32'(valid_m), 32'(1));
        chk("m_hit", 32'(hit_m), 32'(1));
        chk("m_colour", 32'(colour_m), 32'(1));
        tick();
        chk("m_ready_back", 32'(ready_m), 32'(1));
        // The write landed: the same key now misses everywhere
        start_m = 1'b1; rgb_m = 24'h0A0BFF;
        tick();
        start_m = 1'b0;
        wait_valid(1'b1, 0, e);
        chk("m2_edge", 32'(e), 32'(8));
        chk("m2_hit", 32'(hit_m), 32'(0));
        chk("m2_colour", 32'(colour_m), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
